ysyx_23060025_axi_arbiter: RTL and testbench

Two-master, one-slave arbiter that shares the single memory-side AXI-lite bus between the IFU (read-only) and the LSU (read/write).
- Each grant carries one single-beat transaction and is held until that transaction's response handshake completes.
- Round-robin tie-break between the two masters; a non-granted master is stalled by its readys being held low.
- Sits between the IFU/LSU AXI master ports and the memory/crossbar slave port.

---
 rtl/ysyx_23060025_axi_arbiter_pkg.sv | 22 ++
 rtl/ysyx_23060025_arb_rr2.sv | 20 ++
 rtl/ysyx_23060025_axi_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_ysyx_23060025_axi_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060025_axi_arbiter_pkg.sv
// Shared definitions for the IFU/LSU AXI-lite arbiter: grant states, response
// codes and the AXI transfer-size encodings carried through unmodified.
package ysyx_23060025_axi_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_IFU_RD = 2'b01,
    ARB_LSU_RD = 2'b10,
    ARB_LSU_WR = 2'b11
  } arb_state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam logic [2:0] AXI_ADDR_SIZE_BYTE   = 3'b000;
  localparam logic [2:0] AXI_ADDR_SIZE_HALF   = 3'b001;
  localparam logic [2:0] AXI_ADDR_SIZE_WORD   = 3'b010;
  localparam logic [2:0] AXI_ADDR_SIZE_DOUBLE = 3'b011;

  localparam logic GRANT_IFU = 1'b0;
  localparam logic GRANT_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060025_arb_rr2.sv
// Two-requester round-robin picker: a lone requester wins, a tie goes to the
// requester that did not win last time. Bit 0 is the IFU, bit 1 the LSU.
module ysyx_23060025_arb_rr2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_gnt
);

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last_grant ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_23060025_axi_arbiter.sv
// Shares one AXI-lite slave port between the IFU (read-only) and the LSU; each
// grant covers a single transaction and is released after its response handshake.
module ysyx_23060025_axi_arbiter
  import ysyx_23060025_axi_arbiter_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                  clock,
  input  logic                  rstn,
  input  logic [ADDR_LEN-1:0]   ifu_addr_r_addr_i,
  input  logic [2:0]            ifu_addr_r_size_i,
  input  logic                  ifu_addr_r_valid_i,
  output logic                  ifu_addr_r_ready_o,
  output logic [DATA_LEN-1:0]   ifu_r_data_o,
  output logic [1:0]            ifu_r_resp_o,
  output logic                  ifu_r_valid_o,
  input  logic                  ifu_r_ready_i,
  input  logic [ADDR_LEN-1:0]   lsu_addr_r_addr_i,
  input  logic [2:0]            lsu_addr_r_size_i,
  input  logic                  lsu_addr_r_valid_i,
  output logic                  lsu_addr_r_ready_o,
  output logic [DATA_LEN-1:0]   lsu_r_data_o,
  output logic [1:0]            lsu_r_resp_o,
  output logic                  lsu_r_valid_o,
  input  logic                  lsu_r_ready_i,
  input  logic [ADDR_LEN-1:0]   lsu_addr_w_addr_i,
  input  logic [2:0]            lsu_addr_w_size_i,
  input  logic                  lsu_addr_w_valid_i,
  output logic                  lsu_addr_w_ready_o,
  input  logic [DATA_LEN-1:0]   lsu_w_data_i,
  input  logic [DATA_LEN/8-1:0] lsu_w_strb_i,
  input  logic                  lsu_w_valid_i,
  output logic                  lsu_w_ready_o,
  output logic [1:0]            lsu_bkwd_resp_o,
  output logic                  lsu_bkwd_valid_o,
  input  logic                  lsu_bkwd_ready_i,
  output logic [ADDR_LEN-1:0]   mem_addr_r_addr_o,
  output logic [2:0]            mem_addr_r_size_o,
  output logic                  mem_addr_r_valid_o,
  input  logic                  mem_addr_r_ready_i,
  input  logic [DATA_LEN-1:0]   mem_r_data_i,
  input  logic [1:0]            mem_r_resp_i,
  input  logic                  mem_r_valid_i,
  output logic                  mem_r_ready_o,
  output logic [ADDR_LEN-1:0]   mem_addr_w_addr_o,
  output logic [2:0]            mem_addr_w_size_o,
  output logic                  mem_addr_w_valid_o,
  input  logic                  mem_addr_w_ready_i,
  output logic [DATA_LEN-1:0]   mem_w_data_o,
  output logic [DATA_LEN/8-1:0] mem_w_strb_o,
  output logic                  mem_w_valid_o,
  input  logic                  mem_w_ready_i,
  input  logic [1:0]            mem_bkwd_resp_i,
  input  logic                  mem_bkwd_valid_i,
  output logic                  mem_bkwd_ready_o,
  output logic                  arb_err_o
);

  arb_state_e r_state;
  logic       r_last_grant;
  logic       r_err;

  arb_state_e w_state_nxt;
  logic       w_last_grant_nxt;
  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_rd_done;
  logic       w_wr_done;
  logic       w_err_hit;

  assign w_req = {lsu_addr_r_valid_i | lsu_addr_w_valid_i | lsu_w_valid_i, ifu_addr_r_valid_i};

  ysyx_23060025_arb_rr2 u_rr2 (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_gnt)
  );

  // Routing depends only on registered state, so nothing leaks through while idle or in reset.
  always_comb begin
    ifu_addr_r_ready_o = 1'b0;
    ifu_r_data_o       = '0;
    ifu_r_resp_o       = '0;
    ifu_r_valid_o      = 1'b0;
    lsu_addr_r_ready_o = 1'b0;
    lsu_r_data_o       = '0;
    lsu_r_resp_o       = '0;
    lsu_r_valid_o      = 1'b0;
    lsu_addr_w_ready_o = 1'b0;
    lsu_w_ready_o      = 1'b0;
    lsu_bkwd_resp_o    = '0;
    lsu_bkwd_valid_o   = 1'b0;
    mem_addr_r_addr_o  = '0;
    mem_addr_r_size_o  = '0;
    mem_addr_r_valid_o = 1'b0;
    mem_r_ready_o      = 1'b0;
    mem_addr_w_addr_o  = '0;
    mem_addr_w_size_o  = '0;
    mem_addr_w_valid_o = 1'b0;
    mem_w_data_o       = '0;
    mem_w_strb_o       = '0;
    mem_w_valid_o      = 1'b0;
    mem_bkwd_ready_o   = 1'b0;
    case (r_state)
      ARB_IFU_RD: begin
        mem_addr_r_addr_o  = ifu_addr_r_addr_i;
        mem_addr_r_size_o  = ifu_addr_r_size_i;
        mem_addr_r_valid_o = ifu_addr_r_valid_i;
        ifu_addr_r_ready_o = mem_addr_r_ready_i;
        ifu_r_data_o       = mem_r_data_i;
        ifu_r_resp_o       = mem_r_resp_i;
        ifu_r_valid_o      = mem_r_valid_i;
        mem_r_ready_o      = ifu_r_ready_i;
      end
      ARB_LSU_RD: begin
        mem_addr_r_addr_o  = lsu_addr_r_addr_i;
        mem_addr_r_size_o  = lsu_addr_r_size_i;
        mem_addr_r_valid_o = lsu_addr_r_valid_i;
        lsu_addr_r_ready_o = mem_addr_r_ready_i;
        lsu_r_data_o       = mem_r_data_i;
        lsu_r_resp_o       = mem_r_resp_i;
        lsu_r_valid_o      = mem_r_valid_i;
        mem_r_ready_o      = lsu_r_ready_i;
      end
      ARB_LSU_WR: begin
        mem_addr_w_addr_o  = lsu_addr_w_addr_i;
        mem_addr_w_size_o  = lsu_addr_w_size_i;
        mem_addr_w_valid_o = lsu_addr_w_valid_i;
        lsu_addr_w_ready_o = mem_addr_w_ready_i;
        mem_w_data_o       = lsu_w_data_i;
        mem_w_strb_o       = lsu_w_strb_i;
        mem_w_valid_o      = lsu_w_valid_i;
        lsu_w_ready_o      = mem_w_ready_i;
        lsu_bkwd_resp_o    = mem_bkwd_resp_i;
        lsu_bkwd_valid_o   = mem_bkwd_valid_i;
        mem_bkwd_ready_o   = lsu_bkwd_ready_i;
      end
      default: ;
    endcase
  end

  // Only the response handshake ends a grant; the AR/AW/W handshakes never do.
  assign w_rd_done = mem_r_valid_i & mem_r_ready_o;
  assign w_wr_done = mem_bkwd_valid_i & mem_bkwd_ready_o;
  assign w_err_hit = (w_rd_done & (mem_r_resp_i != AXI_RESP_OKAY)) |
                     (w_wr_done & (mem_bkwd_resp_i != AXI_RESP_OKAY));

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      ARB_IDLE: begin
        if (w_gnt[0]) begin
          w_state_nxt      = ARB_IFU_RD;
          w_last_grant_nxt = GRANT_IFU;
        end else if (w_gnt[1]) begin
          w_state_nxt      = lsu_addr_r_valid_i ? ARB_LSU_RD : ARB_LSU_WR;
          w_last_grant_nxt = GRANT_LSU;
        end
      end
      ARB_IFU_RD, ARB_LSU_RD: if (w_rd_done) w_state_nxt = ARB_IDLE;
      ARB_LSU_WR:             if (w_wr_done) w_state_nxt = ARB_IDLE;
      default:                w_state_nxt = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= GRANT_IFU;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_err        <= r_err | w_err_hit;
    end
  end

  assign arb_err_o = r_err;

endmodule

// File: tb/tb_ysyx_23060025_axi_arbiter.sv
// Bench for the IFU/LSU arbiter: directed scenarios plus random traffic, all
// compared each cycle against a transaction-level ownership model.
module tb_ysyx_23060025_axi_arbiter;
  import ysyx_23060025_axi_arbiter_pkg::*;

  localparam int DATA_LEN = 32;
  localparam int ADDR_LEN = 32;

  localparam int O_NONE = 0;
  localparam int O_IFU  = 1;
  localparam int O_LSR  = 2;
  localparam int O_LSW  = 3;

  logic clock = 1'b0;
  logic rstn  = 1'b0;
  always #5 clock = ~clock;

  logic [ADDR_LEN-1:0] ifu_ar_addr, lsu_ar_addr, lsu_aw_addr;
  logic [2:0]          ifu_ar_size, lsu_ar_size, lsu_aw_size;
  logic                ifu_ar_valid, lsu_ar_valid, lsu_aw_valid, lsu_w_valid;
  logic                ifu_r_ready, lsu_r_ready, lsu_b_ready;
  logic [DATA_LEN-1:0] lsu_w_data, mem_r_data;
  logic [3:0]          lsu_w_strb;
  logic                mem_ar_ready, mem_aw_ready, mem_w_ready;
  logic                mem_r_valid, mem_b_valid;
  logic [1:0]          mem_r_resp, mem_b_resp;

  logic                ifu_addr_r_ready_o, ifu_r_valid_o;
  logic [DATA_LEN-1:0] ifu_r_data_o, lsu_r_data_o, mem_w_data_o;
  logic [1:0]          ifu_r_resp_o, lsu_r_resp_o, lsu_bkwd_resp_o;
  logic                lsu_addr_r_ready_o, lsu_r_valid_o, lsu_addr_w_ready_o, lsu_w_ready_o;
  logic                lsu_bkwd_valid_o;
  logic [ADDR_LEN-1:0] mem_addr_r_addr_o, mem_addr_w_addr_o;
  logic [2:0]          mem_addr_r_size_o, mem_addr_w_size_o;
  logic                mem_addr_r_valid_o, mem_r_ready_o, mem_addr_w_valid_o;
  logic [3:0]          mem_w_strb_o;
  logic                mem_w_valid_o, mem_bkwd_ready_o, arb_err_o;

  ysyx_23060025_axi_arbiter #(.DATA_LEN(DATA_LEN), .ADDR_LEN(ADDR_LEN)) dut (
    .clock              (clock),
    .rstn               (rstn),
    .ifu_addr_r_addr_i  (ifu_ar_addr),
    .ifu_addr_r_size_i  (ifu_ar_size),
    .ifu_addr_r_valid_i (ifu_ar_valid),
    .ifu_addr_r_ready_o (ifu_addr_r_ready_o),
    .ifu_r_data_o       (ifu_r_data_o),
    .ifu_r_resp_o       (ifu_r_resp_o),
    .ifu_r_valid_o      (ifu_r_valid_o),
    .ifu_r_ready_i      (ifu_r_ready),
    .lsu_addr_r_addr_i  (lsu_ar_addr),
    .lsu_addr_r_size_i  (lsu_ar_size),
    .lsu_addr_r_valid_i (lsu_ar_valid),
    .lsu_addr_r_ready_o (lsu_addr_r_ready_o),
    .lsu_r_data_o       (lsu_r_data_o),
    .lsu_r_resp_o       (lsu_r_resp_o),
    .lsu_r_valid_o      (lsu_r_valid_o),
    .lsu_r_ready_i      (lsu_r_ready),
    .lsu_addr_w_addr_i  (lsu_aw_addr),
    .lsu_addr_w_size_i  (lsu_aw_size),
    .lsu_addr_w_valid_i (lsu_aw_valid),
    .lsu_addr_w_ready_o (lsu_addr_w_ready_o),
    .lsu_w_data_i       (lsu_w_data),
    .lsu_w_strb_i       (lsu_w_strb),
    .lsu_w_valid_i      (lsu_w_valid),
    .lsu_w_ready_o      (lsu_w_ready_o),
    .lsu_bkwd_resp_o    (lsu_bkwd_resp_o),
    .lsu_bkwd_valid_o   (lsu_bkwd_valid_o),
    .lsu_bkwd_ready_i   (lsu_b_ready),
    .mem_addr_r_addr_o  (mem_addr_r_addr_o),
    .mem_addr_r_size_o  (mem_addr_r_size_o),
    .mem_addr_r_valid_o (mem_addr_r_valid_o),
    .mem_addr_r_ready_i (mem_ar_ready),
    .mem_r_data_i       (mem_r_data),
    .mem_r_resp_i       (mem_r_resp),
    .mem_r_valid_i      (mem_r_valid),
    .mem_r_ready_o      (mem_r_ready_o),
    .mem_addr_w_addr_o  (mem_addr_w_addr_o),
    .mem_addr_w_size_o  (mem_addr_w_size_o),
    .mem_addr_w_valid_o (mem_addr_w_valid_o),
    .mem_addr_w_ready_i (mem_aw_ready),
    .mem_w_data_o       (mem_w_data_o),
    .mem_w_strb_o       (mem_w_strb_o),
    .mem_w_valid_o      (mem_w_valid_o),
    .mem_w_ready_i      (mem_w_ready),
    .mem_bkwd_resp_i    (mem_b_resp),
    .mem_bkwd_valid_i   (mem_b_valid),
    .mem_bkwd_ready_o   (mem_bkwd_ready_o),
    .arb_err_o          (arb_err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who currently owns the slave, who won the last grant, sticky error.
  int   m_own      = O_NONE;
  logic m_last_lsu = 1'b0;
  logic m_err      = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    ifu_ar_addr = '0; ifu_ar_size = '0; ifu_ar_valid = 1'b0; ifu_r_ready = 1'b0;
    lsu_ar_addr = '0; lsu_ar_size = '0; lsu_ar_valid = 1'b0; lsu_r_ready = 1'b0;
    lsu_aw_addr = '0; lsu_aw_size = '0; lsu_aw_valid = 1'b0;
    lsu_w_data  = '0; lsu_w_strb  = '0; lsu_w_valid  = 1'b0; lsu_b_ready = 1'b0;
    mem_ar_ready = 1'b0; mem_aw_ready = 1'b0; mem_w_ready = 1'b0;
    mem_r_data = '0; mem_r_resp = '0; mem_r_valid = 1'b0;
    mem_b_resp = '0; mem_b_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_own = O_NONE; m_last_lsu = 1'b0; m_err = 1'b0;
  endtask

  // Expected outputs: the owner's channels are wired straight through, everything else is 0.
  task automatic model_check();
    logic g_ifu, g_lr, g_lw;
    logic e_ar_valid, e_r_ready;
    logic [ADDR_LEN-1:0] e_ar_addr;
    logic [2:0] e_ar_size;
    g_ifu = (m_own == O_IFU);
    g_lr  = (m_own == O_LSR);
    g_lw  = (m_own == O_LSW);
    e_ar_valid = g_ifu ? ifu_ar_valid : (g_lr ? lsu_ar_valid : 1'b0);
    e_ar_addr  = g_ifu ? ifu_ar_addr  : (g_lr ? lsu_ar_addr  : '0);
    e_ar_size  = g_ifu ? ifu_ar_size  : (g_lr ? lsu_ar_size  : '0);
    e_r_ready  = g_ifu ? ifu_r_ready  : (g_lr ? lsu_r_ready  : 1'b0);
    check("rd_ctrl",
          64'({ifu_addr_r_ready_o, ifu_r_valid_o, lsu_addr_r_ready_o, lsu_r_valid_o,
               mem_addr_r_valid_o, mem_r_ready_o}),
          64'({g_ifu & mem_ar_ready, g_ifu & mem_r_valid, g_lr & mem_ar_ready, g_lr & mem_r_valid,
               e_ar_valid, e_r_ready}));
    check("wr_ctrl",
          64'({lsu_addr_w_ready_o, lsu_w_ready_o, lsu_bkwd_valid_o, mem_addr_w_valid_o,
               mem_w_valid_o, mem_bkwd_ready_o}),
          64'({g_lw & mem_aw_ready, g_lw & mem_w_ready, g_lw & mem_b_valid, g_lw & lsu_aw_valid,
               g_lw & lsu_w_valid, g_lw & lsu_b_ready}));
    check("mem_ar", 64'({mem_addr_r_addr_o, mem_addr_r_size_o}), 64'({e_ar_addr, e_ar_size}));
    check("mem_aw", 64'({mem_addr_w_addr_o, mem_addr_w_size_o}),
          g_lw ? 64'({lsu_aw_addr, lsu_aw_size}) : 64'd0);
    check("mem_w", 64'({mem_w_data_o, mem_w_strb_o}),
          g_lw ? 64'({lsu_w_data, lsu_w_strb}) : 64'd0);
    check("ifu_r", 64'({ifu_r_data_o, ifu_r_resp_o}), g_ifu ? 64'({mem_r_data, mem_r_resp}) : 64'd0);
    check("lsu_r", 64'({lsu_r_data_o, lsu_r_resp_o}), g_lr ? 64'({mem_r_data, mem_r_resp}) : 64'd0);
    check("lsu_b", 64'(lsu_bkwd_resp_o), g_lw ? 64'(mem_b_resp) : 64'd0);
    check("arb_err", 64'(arb_err_o), 64'(m_err));
  endtask

  // Clock-edge update of the model from the inputs that were stable across the edge.
  task automatic model_tick();
    logic ifu_req, lsu_req, pick_lsu, done;
    logic [1:0] resp;
    if (m_own == O_NONE) begin
      ifu_req  = ifu_ar_valid;
      lsu_req  = lsu_ar_valid | lsu_aw_valid | lsu_w_valid;
      pick_lsu = (ifu_req && lsu_req) ? !m_last_lsu : lsu_req;
      if (ifu_req || lsu_req) begin
        if (pick_lsu) begin
          m_own      = lsu_ar_valid ? O_LSR : O_LSW;
          m_last_lsu = 1'b1;
        end else begin
          m_own      = O_IFU;
          m_last_lsu = 1'b0;
        end
      end
    end else begin
      if (m_own == O_LSW) begin
        done = mem_b_valid & lsu_b_ready;
        resp = mem_b_resp;
      end else begin
        done = mem_r_valid & ((m_own == O_IFU) ? ifu_r_ready : lsu_r_ready);
        resp = mem_r_resp;
      end
      if (done) begin
        if (resp != 2'b00) m_err = 1'b1;
        m_own = O_NONE;
      end
    end
  endtask

  task automatic sample();
    #1;
    model_check();
  endtask

  task automatic advance();
    @(posedge clock);
    model_tick();
    @(negedge clock);
  endtask

  task automatic finish_ifu_read();
    ifu_ar_valid = 1'b0; mem_r_valid = 1'b1; ifu_r_ready = 1'b1;
    sample(); advance();
    clear_inputs(); sample(); advance();
  endtask

  task automatic check_all_quiet(input string tag);
    check({tag, "_vr"},
          64'({ifu_addr_r_ready_o, ifu_r_valid_o, lsu_addr_r_ready_o, lsu_r_valid_o,
               lsu_addr_w_ready_o, lsu_w_ready_o, lsu_bkwd_valid_o, mem_addr_r_valid_o,
               mem_r_ready_o, mem_addr_w_valid_o, mem_w_valid_o, mem_bkwd_ready_o}), 64'd0);
    check({tag, "_data"},
          64'({mem_addr_r_addr_o, mem_addr_w_addr_o}) | 64'({mem_w_data_o, mem_w_strb_o,
               mem_addr_r_size_o, mem_addr_w_size_o}), 64'd0);
    check({tag, "_err"}, 64'(arb_err_o), 64'd0);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    @(negedge clock);
    ifu_ar_valid = 1'b1; lsu_ar_valid = 1'b1; mem_ar_ready = 1'b1; mem_w_ready = 1'b1;
    #1;
    check_all_quiet("reset");
    @(negedge clock);
    rstn = 1'b1;
    clear_inputs();
    sample(); advance();

    // IFU alone: forwarded one cycle after the request, data returned, then idle again.
    ifu_ar_valid = 1'b1; ifu_ar_addr = 32'h3000_0000; ifu_ar_size = AXI_ADDR_SIZE_WORD;
    sample();
    check("ifu_bubble", 64'(mem_addr_r_valid_o), 64'd0);
    advance();
    mem_ar_ready = 1'b1;
    sample();
    check("ifu_ar_fwd", 64'({mem_addr_r_valid_o, mem_addr_r_addr_o}), 64'({1'b1, 32'h3000_0000}));
    advance();
    ifu_ar_valid = 1'b0; mem_ar_ready = 1'b0;
    mem_r_valid = 1'b1; mem_r_data = 32'hDEAD_BEEF; mem_r_resp = 2'b00; ifu_r_ready = 1'b1;
    sample();
    check("ifu_r_data", 64'(ifu_r_data_o), 64'h0000_0000_DEAD_BEEF);
    advance();
    clear_inputs(); ifu_ar_valid = 1'b1; mem_ar_ready = 1'b1;
    sample();
    check("ifu_back_idle", 64'(ifu_addr_r_ready_o), 64'd0);
    advance();
    finish_ifu_read();

    // Simultaneous reads straight after reset: LSU wins the first tie.
    rstn = 1'b0; #1; model_reset();
    @(negedge clock); rstn = 1'b1;
    clear_inputs();
    ifu_ar_valid = 1'b1; ifu_ar_addr = 32'h8000_0100;
    lsu_ar_valid = 1'b1; lsu_ar_addr = 32'h8000_2000; mem_ar_ready = 1'b1;
    sample(); advance();
    mem_r_valid = 1'b1; lsu_r_ready = 1'b1; ifu_r_ready = 1'b1; mem_r_data = 32'h1234_5678;
    sample();
    check("tie_lsu_first", 64'({lsu_addr_r_ready_o, ifu_addr_r_ready_o}), 64'd2);
    advance();
    lsu_ar_valid = 1'b0; lsu_r_ready = 1'b0; mem_r_valid = 1'b0;
    sample();
    check("tie_bubble", 64'(ifu_addr_r_ready_o), 64'd0);
    advance();
    sample();
    check("tie_ifu_next", 64'(ifu_addr_r_ready_o), 64'd1);
    advance();
    finish_ifu_read();

    // LSU store with AW, W and B handshakes on separate cycles, IFU waiting meanwhile.
    lsu_aw_valid = 1'b1; lsu_aw_addr = 32'h8000_0040; lsu_aw_size = AXI_ADDR_SIZE_WORD;
    lsu_w_valid = 1'b1; lsu_w_data = 32'hCAFE_F00D; lsu_w_strb = 4'hF;
    sample(); advance();
    mem_aw_ready = 1'b1; ifu_ar_valid = 1'b1; ifu_ar_addr = 32'h3000_0010;
    sample();
    check("st_aw_fwd", 64'({mem_addr_w_valid_o, mem_addr_w_addr_o}), 64'({1'b1, 32'h8000_0040}));
    advance();
    lsu_aw_valid = 1'b0; mem_aw_ready = 1'b0;
    sample(); advance();
    mem_w_ready = 1'b1;
    sample();
    check("st_w_ready", 64'(lsu_w_ready_o), 64'd1);
    advance();
    lsu_w_valid = 1'b0; mem_w_ready = 1'b0; lsu_b_ready = 1'b1;
    sample(); advance();
    mem_b_valid = 1'b1;
    sample();
    check("st_b_held", 64'(lsu_bkwd_valid_o), 64'd1);
    advance();
    mem_b_valid = 1'b0; lsu_b_ready = 1'b0; mem_ar_ready = 1'b1;
    sample();
    check("st_bubble", 64'(ifu_addr_r_ready_o), 64'd0);
    advance();
    sample();
    check("st_ifu_c7", 64'({mem_addr_r_valid_o, mem_addr_r_addr_o}), 64'({1'b1, 32'h3000_0010}));
    advance();
    finish_ifu_read();

    // LSU read and write together: the read goes first, the write waits for its own grant.
    lsu_ar_valid = 1'b1; lsu_ar_addr = 32'h8000_0080;
    lsu_aw_valid = 1'b1; lsu_aw_addr = 32'h8000_00C0; lsu_w_valid = 1'b1; lsu_w_strb = 4'h3;
    mem_ar_ready = 1'b1; mem_aw_ready = 1'b1; mem_w_ready = 1'b1;
    sample(); advance();
    sample();
    check("rw_read_wins", 64'({lsu_addr_r_ready_o, lsu_addr_w_ready_o, lsu_w_ready_o}), 64'd4);
    advance();
    lsu_ar_valid = 1'b0; mem_r_valid = 1'b1; lsu_r_ready = 1'b1;
    sample();
    check("rw_aw_blocked", 64'(lsu_addr_w_ready_o), 64'd0);
    advance();
    mem_r_valid = 1'b0; lsu_r_ready = 1'b0;
    sample(); advance();
    sample();
    check("rw_write_next", 64'({lsu_addr_w_ready_o, lsu_w_ready_o}), 64'd3);
    advance();
    lsu_aw_valid = 1'b0; lsu_w_valid = 1'b0; mem_b_valid = 1'b1; lsu_b_ready = 1'b1;
    sample(); advance();
    clear_inputs(); sample(); advance();

    // SLVERR on B: forwarded as-is, flag rises next cycle and survives later OKAY traffic.
    lsu_aw_valid = 1'b1; lsu_w_valid = 1'b1; mem_aw_ready = 1'b1; mem_w_ready = 1'b1;
    sample(); advance();
    sample(); advance();
    lsu_aw_valid = 1'b0; lsu_w_valid = 1'b0;
    mem_b_valid = 1'b1; mem_b_resp = 2'b10; lsu_b_ready = 1'b1;
    sample();
    check("err_resp_fwd", 64'(lsu_bkwd_resp_o), 64'd2);
    check("err_not_yet", 64'(arb_err_o), 64'd0);
    advance();
    clear_inputs();
    sample();
    check("err_set", 64'(arb_err_o), 64'd1);
    advance();
    ifu_ar_valid = 1'b1; mem_ar_ready = 1'b1;
    sample(); advance();
    finish_ifu_read();
    sample();
    check("err_sticky", 64'(arb_err_o), 64'd1);
    advance();

    // Reset in the middle of a write: everything drops in the same cycle.
    lsu_aw_valid = 1'b1; lsu_w_valid = 1'b1; lsu_w_data = 32'h5555_AAAA;
    sample(); advance();
    sample();
    check("rst_pre_wvalid", 64'(mem_w_valid_o), 64'd1);
    rstn = 1'b0;
    #1;
    check_all_quiet("rst_mid_wr");
    model_reset();
    @(negedge clock);
    rstn = 1'b1;
    clear_inputs();
    sample(); advance();

    // Random traffic against the model.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      ifu_ar_valid = ($urandom_range(0, 99) < 40);
      lsu_ar_valid = ($urandom_range(0, 99) < 25);
      lsu_aw_valid = ($urandom_range(0, 99) < 25);
      lsu_w_valid  = ($urandom_range(0, 99) < 25);
      ifu_r_ready  = ($urandom_range(0, 99) < 60);
      lsu_r_ready  = ($urandom_range(0, 99) < 60);
      lsu_b_ready  = ($urandom_range(0, 99) < 60);
      mem_ar_ready = ($urandom_range(0, 99) < 60);
      mem_aw_ready = ($urandom_range(0, 99) < 60);
      mem_w_ready  = ($urandom_range(0, 99) < 60);
      mem_r_valid  = ($urandom_range(0, 99) < 40);
      mem_b_valid  = ($urandom_range(0, 99) < 40);
      ifu_ar_addr  = $urandom(); lsu_ar_addr = $urandom(); lsu_aw_addr = $urandom();
      ifu_ar_size  = 3'($urandom_range(0, 3));
      lsu_ar_size  = 3'($urandom_range(0, 3));
      lsu_aw_size  = 3'($urandom_range(0, 3));
      lsu_w_data   = $urandom(); lsu_w_strb = 4'($urandom_range(0, 15));
      mem_r_data   = $urandom();
      mem_r_resp   = ($urandom_range(0, 99) < 3) ? 2'($urandom_range(1, 3)) : 2'b00;
      mem_b_resp   = ($urandom_range(0, 99) < 3) ? 2'($urandom_range(1, 3)) : 2'b00;
      sample();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
